// File: rtl/enc_home_speed_ctrl_if.sv
// rtl/enc_home_speed_ctrl_if.sv - encoder pulse inputs and position/speed outputs of the homing/speed sequencer
interface enc_home_speed_ctrl_if;
    logic        enc_step;
    logic        enc_dir;
    logic        enc_index;
    logic        cal_start;
    logic        spd_ready;
    logic [15:0] pos;
    logic        homed;
    logic [15:0] spd;
    logic        spd_valid;
    logic        spd_ovf;
    logic        idx_err;
    logic        fault;
    logic [1:0]  state;

    modport master (
        output enc_step, enc_dir, enc_index, cal_start, spd_ready,
        input  pos, homed, spd, spd_valid, spd_ovf, idx_err, fault, state
    );

    modport slave (
        input  enc_step, enc_dir, enc_index, cal_start, spd_ready,
        output pos, homed, spd, spd_valid, spd_ovf, idx_err, fault, state
    );
endinterface

// File: rtl/enc_home_speed_ctrl.sv
// rtl/enc_home_speed_ctrl.sv - homes encoder position on Z index, tracks wrapped position
// and emits one saturated signed speed sample per fixed window.
module enc_home_speed_ctrl #(
    parameter int ENCO_NUM     = 4000,
    parameter int SPD_PERIOD   = 20000,
    parameter int SEEK_TIMEOUT = 50000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    enc_home_speed_ctrl_if.slave bus
);
    localparam int WIN_W = $clog2(SPD_PERIOD + 1);
    localparam int TMO_W = $clog2(SEEK_TIMEOUT + 1);
    localparam logic [15:0]      POS_MAX  = 16'(ENCO_NUM - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SPD_PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEEK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SEEK = 2'd1, RUN = 2'd2, FAULT = 2'd3} state_t;

    state_t             state_q;
    logic [15:0]        pos_q;
    logic               homed_q;
    logic [15:0]        spd_q;
    logic               spd_valid_q;
    logic               spd_ovf_q;
    logic               idx_err_q;
    logic               fault_q;
    logic [WIN_W-1:0]   win_q;
    logic [TMO_W-1:0]   tmo_q;
    logic signed [15:0] acc_q;

    logic [15:0]        pos_step;
    logic signed [15:0] acc_next;

    always_comb begin
        pos_step = pos_q;
        if (bus.enc_step) begin
            if (bus.enc_dir)
                pos_step = (pos_q == POS_MAX) ? 16'd0 : pos_q + 16'd1;
            else
                pos_step = (pos_q == 16'd0) ? POS_MAX : pos_q - 16'd1;
        end
    end

    // Accumulator saturates rather than wrapping so a runaway window reads as full-scale.
    always_comb begin
        acc_next = acc_q;
        if (bus.enc_step) begin
            if (bus.enc_dir) begin
                if (acc_q != 16'sh7fff) acc_next = acc_q + 16'sd1;
            end else begin
                if (acc_q != 16'sh8000) acc_next = acc_q - 16'sd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pos_q       <= 16'd0;
            homed_q     <= 1'b0;
            spd_q       <= 16'd0;
            spd_valid_q <= 1'b0;
            spd_ovf_q   <= 1'b0;
            idx_err_q   <= 1'b0;
            fault_q     <= 1'b0;
            win_q       <= '0;
            tmo_q       <= '0;
            acc_q       <= 16'sd0;
        end else begin
            pos_q <= pos_step;
            if (spd_valid_q && bus.spd_ready) spd_valid_q <= 1'b0;

            if (bus.cal_start) begin
                state_q     <= SEEK;
                homed_q     <= 1'b0;
                fault_q     <= 1'b0;
                spd_valid_q <= 1'b0;
                spd_ovf_q   <= 1'b0;
                idx_err_q   <= 1'b0;
                win_q       <= '0;
                tmo_q       <= '0;
                acc_q       <= 16'sd0;
            end else begin
                case (state_q)
                    SEEK: begin
                        if (bus.enc_index) begin
                            pos_q   <= 16'd0;
                            homed_q <= 1'b1;
                            state_q <= RUN;
                        end else if (tmo_q == TMO_LAST) begin
                            fault_q <= 1'b1;
                            state_q <= FAULT;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    RUN: begin
                        if (bus.enc_index && pos_step != 16'd0) begin
                            idx_err_q <= 1'b1;
                            pos_q     <= 16'd0;
                        end
                        // Terminal count publishes acc including this cycle's step.
                        if (win_q == WIN_LAST) begin
                            win_q       <= '0;
                            acc_q       <= 16'sd0;
                            spd_q       <= acc_next;
                            spd_valid_q <= 1'b1;
                            if (spd_valid_q && !bus.spd_ready) spd_ovf_q <= 1'b1;
                        end else begin
                            win_q <= win_q + WIN_W'(1);
                            acc_q <= acc_next;
                        end
                    end
                    default: spd_valid_q <= 1'b0;
                endcase
            end
        end
    end

    assign bus.pos       = pos_q;
    assign bus.homed     = homed_q;
    assign bus.spd       = spd_q;
    assign bus.spd_valid = spd_valid_q;
    assign bus.spd_ovf   = spd_ovf_q;
    assign bus.idx_err   = idx_err_q;
    assign bus.fault     = fault_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_enc_home_speed_ctrl.sv
// tb/tb_enc_home_speed_ctrl.sv - directed vector bench for enc_home_speed_ctrl
module tb_enc_home_speed_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    enc_home_speed_ctrl_if bus();

    enc_home_speed_ctrl #(
        .ENCO_NUM(4000),
        .SPD_PERIOD(100),
        .SEEK_TIMEOUT(1000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    typedef struct {
        logic        cal;
        logic        idx;
        logic        step;
        logic        dir;
        logic [1:0]  st;
        logic [15:0] pos;
        logic        homed;
        logic        ierr;
    } vec_t;

    vec_t vecs[18];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic cal, input logic idx, input logic step, input logic dir,
                                input logic [1:0] st, input logic [15:0] pos, input logic homed,
                                input logic ierr);
        vec_t v;
        v.cal = cal; v.idx = idx; v.step = step; v.dir = dir;
        v.st = st; v.pos = pos; v.homed = homed; v.ierr = ierr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cal, input logic idx, input logic step, input logic dir,
                         input logic rdy);
        bus.cal_start = cal;
        bus.enc_index = idx;
        bus.enc_step  = step;
        bus.enc_dir   = dir;
        bus.spd_ready = rdy;
    endtask

    task automatic home();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pos"},   32'(bus.pos), 32'd0);
        chk({tag, "_homed"}, 32'(bus.homed), 32'd0);
        chk({tag, "_spd"},   32'(bus.spd), 32'd0);
        chk({tag, "_valid"}, 32'(bus.spd_valid), 32'd0);
        chk({tag, "_ovf"},   32'(bus.spd_ovf), 32'd0);
        chk({tag, "_ierr"},  32'(bus.idx_err), 32'd0);
        chk({tag, "_fault"}, 32'(bus.fault), 32'd0);
        chk({tag, "_state"}, 32'(bus.state), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 1, 1, 2'd0, 16'd1,    0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 2'd1, 16'd1,    0, 0);
        vecs[2]  = mk(0, 0, 1, 1, 2'd1, 16'd2,    0, 0);
        vecs[3]  = mk(0, 0, 1, 1, 2'd1, 16'd3,    0, 0);
        vecs[4]  = mk(0, 0, 1, 1, 2'd1, 16'd4,    0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 2'd2, 16'd0,    1, 0);
        vecs[6]  = mk(0, 0, 1, 0, 2'd2, 16'd3999, 1, 0);
        vecs[7]  = mk(0, 0, 1, 1, 2'd2, 16'd0,    1, 0);
        vecs[8]  = mk(0, 0, 1, 0, 2'd2, 16'd3999, 1, 0);
        vecs[9]  = mk(0, 1, 1, 1, 2'd2, 16'd0,    1, 0);
        vecs[10] = mk(0, 0, 1, 1, 2'd2, 16'd1,    1, 0);
        vecs[11] = mk(0, 0, 1, 1, 2'd2, 16'd2,    1, 0);
        vecs[12] = mk(0, 0, 1, 1, 2'd2, 16'd3,    1, 0);
        vecs[13] = mk(0, 0, 1, 1, 2'd2, 16'd4,    1, 0);
        vecs[14] = mk(0, 0, 1, 1, 2'd2, 16'd5,    1, 0);
        vecs[15] = mk(0, 1, 0, 0, 2'd2, 16'd0,    1, 1);
        vecs[16] = mk(1, 1, 0, 0, 2'd1, 16'd0,    0, 0);
        vecs[17] = mk(0, 1, 0, 0, 2'd2, 16'd0,    1, 0);

        drive(0, 0, 0, 0, 1);
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].cal, vecs[i].idx, vecs[i].step, vecs[i].dir, 1'b1);
            tick();
            chk($sformatf("v%0d_state", i), 32'(bus.state),   32'(vecs[i].st));
            chk($sformatf("v%0d_pos", i),   32'(bus.pos),     32'(vecs[i].pos));
            chk($sformatf("v%0d_homed", i), 32'(bus.homed),   32'(vecs[i].homed));
            chk($sformatf("v%0d_ierr", i),  32'(bus.idx_err), 32'(vecs[i].ierr));
            chk($sformatf("v%0d_valid", i), 32'(bus.spd_valid), 32'd0);
        end

        // One window of 25 up-steps with the consumer always ready
        home();
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, i < 25, 1, 1);
            tick();
            if (i == 98) chk("w1_valid_early", 32'(bus.spd_valid), 32'd0);
        end
        chk("w1_valid", 32'(bus.spd_valid), 32'd1);
        chk("w1_spd",   32'(bus.spd), 32'd25);
        chk("w1_pos",   32'(bus.pos), 32'd25);
        drive(0, 0, 0, 0, 1);
        tick();
        chk("w1_valid_clr", 32'(bus.spd_valid), 32'd0);

        // Overwrite of an unaccepted sample
        home();
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, i < 25, 1, 0);
            tick();
        end
        chk("wa_valid", 32'(bus.spd_valid), 32'd1);
        chk("wa_spd",   32'(bus.spd), 32'd25);
        chk("wa_ovf",   32'(bus.spd_ovf), 32'd0);
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, i < 10, 0, 0);
            tick();
            if (i == 50) chk("wb_spd_hold", 32'(bus.spd), 32'd25);
        end
        chk("wb_spd",   32'(bus.spd), 32'h0000fff6);
        chk("wb_valid", 32'(bus.spd_valid), 32'd1);
        chk("wb_ovf",   32'(bus.spd_ovf), 32'd1);
        drive(0, 0, 0, 0, 1);
        tick();
        chk("wb_valid_clr", 32'(bus.spd_valid), 32'd0);
        chk("wb_ovf_sticky", 32'(bus.spd_ovf), 32'd1);

        // New sample in the same cycle as acceptance: valid stays, no overflow
        home();
        chk("home_ovf_clr", 32'(bus.spd_ovf), 32'd0);
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, i < 8, 1, 0);
            tick();
        end
        chk("wc_spd", 32'(bus.spd), 32'd8);
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, i < 3, 1, i == 99);
            tick();
        end
        chk("wd_valid", 32'(bus.spd_valid), 32'd1);
        chk("wd_spd",   32'(bus.spd), 32'd3);
        chk("wd_ovf",   32'(bus.spd_ovf), 32'd0);

        // Asynchronous reset mid-window with a pending sample
        drive(0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_valid", 32'(bus.spd_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        check_all_zero("midrst");
        tick();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Homing timeout, then pos tracking in FAULT and recovery
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 999; i++) tick();
        chk("tmo_state_999", 32'(bus.state), 32'd1);
        chk("tmo_fault_999", 32'(bus.fault), 32'd0);
        tick();
        chk("tmo_state", 32'(bus.state), 32'd3);
        chk("tmo_fault", 32'(bus.fault), 32'd1);
        drive(0, 0, 1, 0, 0); tick();
        chk("fault_pos", 32'(bus.pos), 32'd3999);
        chk("fault_valid", 32'(bus.spd_valid), 32'd0);
        drive(1, 0, 0, 0, 0); tick();
        chk("recal_state", 32'(bus.state), 32'd1);
        chk("recal_fault", 32'(bus.fault), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
